// File: rtl/io_event_collector.sv
// Collects masked per-line event pulses and an external event stream into one ordered FWFT FIFO.
// Define IO_EVT_TIMESTAMP_EN to store a 16-bit capture timestamp with every entry.
module io_event_collector #(
    parameter int unsigned N_CH       = 32,
    parameter int unsigned EVT_PER_CH = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned EVT_DATA_W = 8,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                           sys_clk_i,
    input  logic                           sys_rst_i,
    input  logic [N_CH*EVT_PER_CH-1:0]     events_i,
    input  logic [N_CH*EVT_PER_CH-1:0]     evt_mask_i,
    input  logic                           event_valid_i,
    input  logic [EVT_DATA_W-1:0]          event_data_i,
    output logic                           event_ready_o,
    output logic                           evt_valid_o,
    output logic [EVT_DATA_W-1:0]          evt_data_o,
    output logic                           evt_src_o,
    output logic [15:0]                    evt_ts_o,
    input  logic                           evt_ready_i,
    output logic [DROP_CNT_W-1:0]          drop_cnt_o,
    input  logic                           drop_clr_i
);

    localparam int unsigned NumLines = N_CH * EVT_PER_CH;
    localparam int unsigned LineW    = (NumLines > 1) ? $clog2(NumLines) : 1;
    localparam int unsigned AddrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned SumW     = DROP_CNT_W + LineW + 2;

    if (64'(NumLines) > (64'd1 << EVT_DATA_W)) begin : g_id_width_check
        $error("io_event_collector: N_CH*EVT_PER_CH exceeds 2**EVT_DATA_W");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("io_event_collector: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [NumLines-1:0]   pending_q, pending_d;
    logic [LineW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  prio_q, prio_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]        count_q;

    logic [EVT_DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] src_mem;

    logic                  grant_found;
    logic [LineW-1:0]      grant_idx;
    int unsigned           scan_idx;
    logic                  full, empty, int_req, conflict;
    logic                  push_ext, push_int, push, pop;
    logic [NumLines-1:0]   grant_vec, cap_vec, drop_vec;
    logic [LineW:0]        drop_n;
    logic [SumW-1:0]       drop_sum;
    logic [EVT_DATA_W-1:0] push_data;

    // Round-robin scan over registered pending bits, starting at rr_ptr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < NumLines; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NumLines) scan_idx = scan_idx - NumLines;
            if (!grant_found && pending_q[LineW'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = LineW'(scan_idx);
            end
        end
    end

    always_comb begin
        full     = (count_q == (AddrW + 1)'(FIFO_DEPTH));
        empty    = (count_q == '0);
        int_req  = grant_found;
        conflict = !full && event_valid_i && int_req;
        // The external source is held off in the cycles where the internal side wins.
        event_ready_o = !sys_rst_i && !full && !(event_valid_i && int_req && prio_q);
        push_ext  = event_valid_i && event_ready_o;
        push_int  = int_req && !full && !push_ext;
        push      = push_ext || push_int;
        pop       = !empty && evt_ready_i;
        push_data = push_ext ? event_data_i : EVT_DATA_W'(grant_idx);
        prio_d    = conflict ? !prio_q : prio_q;
    end

    always_comb begin
        grant_vec = '0;
        rr_ptr_d  = rr_ptr_q;
        if (push_int) begin
            grant_vec[grant_idx] = 1'b1;
            rr_ptr_d = (32'(grant_idx) == NumLines - 1) ? '0 : grant_idx + 1'b1;
        end
        cap_vec   = events_i & ~evt_mask_i;
        drop_vec  = cap_vec & pending_q & ~grant_vec;
        pending_d = (pending_q & ~grant_vec) | cap_vec;
    end

    always_comb begin
        drop_n = '0;
        for (int unsigned i = 0; i < NumLines; i++) begin
            drop_n = drop_n + (LineW + 1)'(drop_vec[i]);
        end
        drop_sum = SumW'(drop_cnt_q) + SumW'(drop_n);
        if (drop_clr_i) begin
            drop_cnt_d = '0;
        end else if (|drop_sum[SumW-1:DROP_CNT_W]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            prio_q     <= 1'b0;
            drop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            prio_q     <= prio_d;
            drop_cnt_q <= drop_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push && !sys_rst_i) begin
            data_mem[wr_ptr_q] <= push_data;
            src_mem[wr_ptr_q]  <= push_ext;
        end
    end

    always_comb begin
        evt_valid_o = !empty;
        evt_data_o  = empty ? '0 : data_mem[rd_ptr_q];
        evt_src_o   = empty ? 1'b0 : src_mem[rd_ptr_q];
        drop_cnt_o  = drop_cnt_q;
    end

`ifdef IO_EVT_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem [FIFO_DEPTH];

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push && !sys_rst_i) begin
            ts_mem[wr_ptr_q] <= ts_q;
        end
    end

    always_comb begin
        evt_ts_o = empty ? '0 : ts_mem[rd_ptr_q];
    end
`else
    always_comb begin
        evt_ts_o = '0;
    end
`endif

endmodule

// File: tb/tb_io_event_collector.sv
// Self-checking bench for io_event_collector: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_io_event_collector;

    localparam int N     = 128;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] events, mask;
    logic         ext_valid, ext_ready;
    logic [7:0]   ext_data;
    logic         out_valid, out_src, out_ready;
    logic [7:0]   out_data;
    logic [15:0]  out_ts, drop_cnt;
    logic         drop_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_event_collector dut (
        .sys_clk_i     (clk),
        .sys_rst_i     (rst),
        .events_i      (events),
        .evt_mask_i    (mask),
        .event_valid_i (ext_valid),
        .event_data_i  (ext_data),
        .event_ready_o (ext_ready),
        .evt_valid_o   (out_valid),
        .evt_data_o    (out_data),
        .evt_src_o     (out_src),
        .evt_ts_o      (out_ts),
        .evt_ready_i   (out_ready),
        .drop_cnt_o    (drop_cnt),
        .drop_clr_i    (drop_clr)
    );

    // Behavioural model: pending set, round-robin start, priority flag, FIFO queue.
    typedef struct {
        bit src;
        int id;
        int ts;
    } ent_t;

    bit   m_pend [N];
    int   m_rr;
    bit   m_prio;
    ent_t m_q [$];
    int   m_drop;
    int   m_ts;

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_ready();
        return !rst && (m_q.size() < DEPTH) && !(ext_valid && (m_grant() >= 0) && m_prio);
    endfunction

    task automatic model_edge();
        int   g;
        int   nd;
        bit   full, push_e, push_i;
        ent_t e;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_rr = 0; m_prio = 1'b0; m_q.delete(); m_drop = 0; m_ts = 0;
            return;
        end
        g = m_grant();
        full = (m_q.size() == DEPTH);
        push_e = 1'b0; push_i = 1'b0;
        if (!full) begin
            if (ext_valid && g >= 0) begin
                if (m_prio) push_i = 1'b1; else push_e = 1'b1;
                m_prio = !m_prio;
            end else if (ext_valid) begin
                push_e = 1'b1;
            end else if (g >= 0) begin
                push_i = 1'b1;
            end
        end
        if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        if (push_e) begin
            e.src = 1'b1; e.id = int'(ext_data); e.ts = m_ts; m_q.push_back(e);
        end
        if (push_i) begin
            e.src = 1'b0; e.id = g; e.ts = m_ts; m_q.push_back(e);
            m_pend[g] = 1'b0;
            m_rr = (g + 1) % N;
        end
        nd = 0;
        for (int i = 0; i < N; i++) begin
            if (events[7'(i)] && !mask[7'(i)]) begin
                if (m_pend[i]) nd++;
                m_pend[i] = 1'b1;
            end
        end
        if (drop_clr) m_drop = 0;
        else m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
        m_ts = (m_ts + 1) & 16'hFFFF;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; events = '0; mask = '0; ext_valid = 1'b0; ext_data = '0;
        out_ready = 1'b0; drop_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    int lines [10] = '{0, 11, 20, 33, 47, 58, 64, 77, 90, 127};

    task automatic test_reset();
        rst = 1'b1; events = '1; ext_valid = 1'b1; ext_data = 8'h11;
        #2;
        checks++;
        if (ext_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ext_ready); end
        step();
        step();
        rst = 1'b0; events = '0; ext_valid = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++;
        if (out_src !== 1'b0) begin failures++; $display("FAIL reset_src: got %b want 0", out_src); end
        checks++;
        if (out_ts !== 16'h0) begin failures++; $display("FAIL reset_ts: got %h want 0", out_ts); end
        checks++;
        if (drop_cnt !== 16'h0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_single_line();
        out_ready = 1'b0;
        repeat (10) step();
        events = '0; events[5] = 1'b1;
        step();
        events = '0;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_t1_valid: got %b want 0", out_valid); end
        step();
        #2;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h05 || out_src !== 1'b0) begin
            failures++;
            $display("FAIL single_t2: got v=%b d=%h s=%b want v=1 d=05 s=0", out_valid, out_data, out_src);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pop: got %b want 0", out_valid); end
    endtask

    task automatic test_rr_order();
        logic [7:0] exp_seq [3];
        exp_seq = '{8'h03, 8'h07, 8'h64};
        do_reset();
        out_ready = 1'b1;
        events[3] = 1'b1; events[7] = 1'b1; events[100] = 1'b1;
        step();
        events = '0;
        step();
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[k]) begin
                failures++;
                $display("FAIL rr_order[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_seq[k]);
            end
            step();
        end
        #2;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_order_end: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int k = 0; k < 10; k++) events[7'(lines[k])] = 1'b1;
        step();
        events = '0;
        repeat (11) step();
        #2;
        checks++;
        if (out_valid !== 1'b1 || ext_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_state: got v=%b rdy=%b want v=1 rdy=0", out_valid, ext_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(lines[k])) begin
                failures++;
                $display("FAIL full_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'(lines[k]));
            end
            step();
            #2;
        end
        checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'h0) begin
            failures++;
            $display("FAIL full_end: got v=%b drop=%0d want v=0 drop=0", out_valid, drop_cnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        for (int k = 0; k < 10; k++) events[7'(lines[k])] = 1'b1;
        step();
        events = '0;
        repeat (11) step();
        events[9] = 1'b1;
        step();
        events = '0;
        step();
        events[9] = 1'b1;
        step();
        events = '0;
        #2;
        checks++;
        if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_count: got %0d want 1", drop_cnt); end
        drop_clr = 1'b1; events[9] = 1'b1;
        step();
        drop_clr = 1'b0; events = '0;
        #2;
        checks++;
        if (drop_cnt !== 16'd0) begin failures++; $display("FAIL drop_clr_prio: got %0d want 0", drop_cnt); end
        out_ready = 1'b1;
        repeat (16) step();
        out_ready = 1'b0;
    endtask

    task automatic test_ext_alternate();
        do_reset();
        out_ready = 1'b1;
        events[2] = 1'b1;
        step();
        ext_valid = 1'b1; ext_data = 8'hA5;
        for (int k = 0; k < 6; k++) begin
            #2;
            checks++;
            if (ext_ready !== ((k % 2) == 0)) begin
                failures++;
                $display("FAIL alt_ready[%0d]: got %b want %b", k, ext_ready, (k % 2) == 0);
            end
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_src !== ((k % 2) == 1)
                    || out_data !== (((k % 2) == 1) ? 8'hA5 : 8'h02)) begin
                    failures++;
                    $display("FAIL alt_out[%0d]: got v=%b s=%b d=%h", k, out_valid, out_src, out_data);
                end
            end
            step();
        end
        ext_valid = 1'b0; events = '0;
        repeat (4) step();
        out_ready = 1'b0;
    endtask

    task automatic test_timestamp();
        logic [15:0] exp_ts;
`ifdef IO_EVT_TIMESTAMP_EN
        exp_ts = 16'd20;
`else
        exp_ts = 16'd0;
`endif
        do_reset();
        repeat (20) step();
        ext_valid = 1'b1; ext_data = 8'h3C;
        #2;
        checks++;
        if (ext_ready !== 1'b1) begin failures++; $display("FAIL ts_ready: got %b want 1", ext_ready); end
        step();
        ext_valid = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== 8'h3C || out_ts !== exp_ts) begin
            failures++;
            $display("FAIL ts_value: got v=%b s=%b d=%h ts=%0d want ts=%0d", out_valid, out_src, out_data, out_ts, exp_ts);
        end
    endtask

    task automatic test_random();
        bit         hold;
        logic       e_valid, e_src, e_ready;
        logic [7:0] e_data;
        logic [15:0] e_ts;
        logic [6:0] idx;
        int         n;
        do_reset();
        hold = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            events = '0;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                idx = (c % 400 < 200) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, N - 1));
                events[idx] = 1'b1;
            end
            mask = '0;
            if ($urandom_range(0, 7) == 0) begin
                for (int w = 0; w < 4; w++) mask[w*32 +: 32] = $urandom & $urandom & $urandom;
            end
            if (!hold) begin
                ext_valid = ($urandom_range(0, 2) == 0);
                ext_data  = 8'($urandom);
            end
            out_ready = (c < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            drop_clr  = ($urandom_range(0, 63) == 0);
            #2;
            e_valid = (m_q.size() > 0);
            e_data  = e_valid ? 8'(m_q[0].id) : 8'h00;
            e_src   = e_valid ? m_q[0].src : 1'b0;
`ifdef IO_EVT_TIMESTAMP_EN
            e_ts    = e_valid ? 16'(m_q[0].ts) : 16'h0;
`else
            e_ts    = 16'h0;
`endif
            e_ready = m_ready();
            checks++;
            if (out_valid !== e_valid || out_data !== e_data || out_src !== e_src) begin
                failures++;
                $display("FAIL rand_head[%0d]: got v=%b d=%h s=%b want v=%b d=%h s=%b",
                         c, out_valid, out_data, out_src, e_valid, e_data, e_src);
            end
            checks++;
            if (out_ts !== e_ts) begin
                failures++;
                $display("FAIL rand_ts[%0d]: got %0d want %0d", c, out_ts, e_ts);
            end
            checks++;
            if (ext_ready !== e_ready) begin
                failures++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, ext_ready, e_ready);
            end
            checks++;
            if (drop_cnt !== 16'(m_drop)) begin
                failures++;
                $display("FAIL rand_drop[%0d]: got %0d want %0d", c, drop_cnt, m_drop);
            end
            hold = ext_valid && !e_ready;
            step();
        end
        rst = 1'b0; events = '0; mask = '0; ext_valid = 1'b0; drop_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; events = '0; mask = '0; ext_valid = 1'b0; ext_data = '0;
        out_ready = 1'b0; drop_clr = 1'b0;
        #1;
        test_reset();
        test_single_line();
        test_rr_order();
        test_fifo_full();
        test_drop();
        test_ext_alternate();
        test_timestamp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
